// File: rtl/button_pkg.sv
// Shared types and defaults for the push-button conditioning block.
// Latency: n/a (types only). Backpressure: n/a.
// Holds the FSM state encoding, default timing constants and a counter-width helper.
package button_pkg;

    typedef enum logic [1:0] {
        RELEASED     = 2'd0,
        PRESS_WAIT   = 2'd1,
        HELD         = 2'd2,
        RELEASE_WAIT = 2'd3
    } btn_state_t;

    localparam int BTN_DEBOUNCE_DEFAULT = 120_000;
    localparam int BTN_LONG_DEFAULT     = 12_000_000;

    // One counter width serves both the debounce and the long-press counters.
    function automatic int btn_cnt_width(input int a, input int b);
        return $clog2((a > b) ? a : b) + 1;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for one asynchronous pin, reset to a chosen idle level.
// Latency: 2 CLK cycles. Backpressure: none, free-running.
// Synchronous active-low reset.
module sync_2ff #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            meta <= RST_VAL;
            q    <= RST_VAL;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/button_debouncer.sv
// Debounces one push-button into a level plus press/release/long-press strobes.
// Latency: PRESS/RELEASE 2+DEBOUNCE_CYCLES cycles after the pin edge; no backpressure.
// Optional macro BTN_LONG_PRESS_EN builds the long-press counter; otherwise LONG is tied low.
module button_debouncer
    import button_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = BTN_DEBOUNCE_DEFAULT,
    parameter int LONG_CYCLES     = BTN_LONG_DEFAULT,
    parameter bit ACTIVE_LOW      = 1'b0
) (
    input  logic CLK,
    input  logic RST_N,
    input  logic BTN,
    output logic PRESSED,
    output logic PRESS,
    output logic RELEASE,
    output logic LONG
);

    localparam int               CNT_W    = btn_cnt_width(DEBOUNCE_CYCLES, LONG_CYCLES);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic btn_sync;
    logic s;

    sync_2ff #(
        .RST_VAL (ACTIVE_LOW)
    ) u_sync (
        .CLK   (CLK),
        .RST_N (RST_N),
        .d     (BTN),
        .q     (btn_sync)
    );

    assign s = btn_sync ^ ACTIVE_LOW;

    btn_state_t       state, state_n;
    logic [CNT_W-1:0] dcnt, dcnt_n;
    logic             press_n, release_n, pressed_n;

    always_comb begin
        state_n   = state;
        dcnt_n    = dcnt;
        press_n   = 1'b0;
        release_n = 1'b0;
        case (state)
            RELEASED: begin
                if (s) begin
                    state_n = PRESS_WAIT;
                    dcnt_n  = CNT_ONE;
                end
            end
            PRESS_WAIT: begin
                if (!s) begin
                    state_n = RELEASED;
                    dcnt_n  = '0;
                end else if (dcnt == DEB_LAST) begin
                    state_n = HELD;
                    dcnt_n  = '0;
                    press_n = 1'b1;
                end else begin
                    dcnt_n = dcnt + CNT_ONE;
                end
            end
            HELD: begin
                if (!s) begin
                    state_n = RELEASE_WAIT;
                    dcnt_n  = CNT_ONE;
                end
            end
            RELEASE_WAIT: begin
                if (s) begin
                    state_n = HELD;
                    dcnt_n  = '0;
                end else if (dcnt == DEB_LAST) begin
                    state_n   = RELEASED;
                    dcnt_n    = '0;
                    release_n = 1'b1;
                end else begin
                    dcnt_n = dcnt + CNT_ONE;
                end
            end
            default: begin
                state_n = RELEASED;
                dcnt_n  = '0;
            end
        endcase
        pressed_n = (state_n == HELD) || (state_n == RELEASE_WAIT);
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state   <= RELEASED;
            dcnt    <= '0;
            PRESSED <= 1'b0;
            PRESS   <= 1'b0;
            RELEASE <= 1'b0;
        end else begin
            state   <= state_n;
            dcnt    <= dcnt_n;
            PRESSED <= pressed_n;
            PRESS   <= press_n;
            RELEASE <= release_n;
        end
    end

`ifdef BTN_LONG_PRESS_EN
    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYCLES - 1);
    localparam logic [CNT_W-1:0] LONG_PRE  = CNT_W'(LONG_CYCLES - 2);

    logic [CNT_W-1:0] lcnt, lcnt_n;
    logic             long_done, long_done_n, long_n;

    // lcnt survives a rejected release glitch; only a fresh press restarts it.
    always_comb begin
        lcnt_n      = lcnt;
        long_done_n = long_done;
        long_n      = 1'b0;
        if (press_n) begin
            lcnt_n = '0;
        end else if (state == HELD && s && lcnt != LONG_LAST) begin
            lcnt_n = lcnt + CNT_ONE;
            if (lcnt == LONG_PRE && !long_done) begin
                long_n      = 1'b1;
                long_done_n = 1'b1;
            end
        end
        if (state_n == RELEASED) begin
            long_done_n = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            lcnt      <= '0;
            long_done <= 1'b0;
            LONG      <= 1'b0;
        end else begin
            lcnt      <= lcnt_n;
            long_done <= long_done_n;
            LONG      <= long_n;
        end
    end
`else
    assign LONG = 1'b0;
`endif

endmodule

// File: doc/button_debouncer.md
# button_debouncer

Conditions one raw mechanical push-button (Alhambra II SW1/SW2) for the 12 MHz `CLK` domain. It synchronizes the pin, rejects contact bounce and emits a clean level plus single-cycle press, release and long-press strobes. It sits directly upstream of the LED blinker and other user-facing logic, which consume the strobes as enables or mode-step events.

## Interface
- `DEBOUNCE_CYCLES`, 120_000: consecutive stable synchronized samples needed to accept a change (10 ms at 12 MHz); legal range ≥2.
- `LONG_CYCLES`, 12_000_000: cycles in HELD, counted from PRESS, before LONG fires (1 s); legal range ≥2.
- `ACTIVE_LOW`, 0: 1 = the button pulls the pin low when pressed.
- `CLK` in 1: 12 MHz system clock; everything is on its rising edge.
- `RST_N` in 1: synchronous, active-low reset.
- `BTN` in 1: raw asynchronous button pin.
- `PRESSED` out 1: debounced level; 1 while the button is accepted as pressed.
- `PRESS` out 1: one-cycle strobe on an accepted press.
- `RELEASE` out 1: one-cycle strobe on an accepted release.
- `LONG` out 1: one-cycle strobe, at most once per press, after a hold of `LONG_CYCLES`.

## Operation
- Input path: two-flop synchronizer, then polarity normalisation into internal signal `s` (1 = pressed).
- Reset state is RELEASED with all counters 0. FSM states and transitions:
  - RELEASED: when `s`=1, go to PRESS_WAIT and set `dcnt`=1.
  - PRESS_WAIT:
    - `s`=0: back to RELEASED, clear `dcnt`. This is bounce rejection.
    - `s`=1 and `dcnt`=DEBOUNCE_CYCLES-1: go to HELD, pulse PRESS, clear `lcnt`.
    - Otherwise increment `dcnt`.
  - HELD: when `s`=0, go to RELEASE_WAIT and set `dcnt`=1. Otherwise `lcnt` increments, saturating at LONG_CYCLES-1.
  - RELEASE_WAIT:
    - `s`=1: back to HELD. `lcnt` is kept, not cleared, and LONG is not re-armed.
    - `s`=0 and `dcnt`=DEBOUNCE_CYCLES-1: go to RELEASED and pulse RELEASE.
    - Otherwise increment `dcnt`.
- LONG:
  - Pulses in the cycle `lcnt` reaches LONG_CYCLES-1 while in HELD.
  - A sticky `long_done` flag blocks any repeat. The flag clears on entry to RELEASED.
- `PRESSED` is 1 in HELD and RELEASE_WAIT, and 0 otherwise.
- Counter widths are `$clog2` of the larger parameter plus 1. Counters never wrap.
- Simultaneous events:
  - PRESS and LONG are never in the same cycle, because LONG_CYCLES ≥2.
  - RELEASE never coincides with PRESS or LONG.
- Reset mid-operation: outputs drop the cycle after `RST_N` is sampled low, and no RELEASE strobe is emitted.

## Timing
- All outputs are registered.
- Reset values: `PRESSED`=0, `PRESS`=0, `RELEASE`=0, `LONG`=0.
- Latency for a clean edge at `BTN`, counting rising edges from the first edge that samples the new level:
  - PRESS is high in cycle 2+DEBOUNCE_CYCLES.
  - `PRESSED` rises in the same cycle as PRESS.
  - RELEASE follows the same rule relative to a release edge.
- LONG is high LONG_CYCLES-1 cycles after the PRESS cycle, provided the button stays accepted as pressed.
- Each strobe is exactly 1 cycle wide.
- Minimum accepted pulse width at `BTN` is DEBOUNCE_CYCLES cycles. Shorter pulses produce no output.

## Configuration
- `BTN_LONG_PRESS_EN`:
  - Defined: `lcnt`, `long_done` and the LONG logic are built as described above.
  - Undefined: `LONG` is tied to 0, `lcnt` and `long_done` are not instantiated, and `LONG_CYCLES` is ignored. All other behaviour and timing are identical.

## Structure
- Shared package `button_pkg` holds:
  - enum `btn_state_t` with values RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT;
  - default constants `BTN_DEBOUNCE_DEFAULT` and `BTN_LONG_DEFAULT`.
- One sub-module, `sync_2ff`: a two-flop synchronizer with a reset value parameter. It resets to the idle (unpressed) pin level.
- The FSM and counters live in `button_debouncer`.

## Test plan
Run all scenarios with DEBOUNCE_CYCLES=4 and LONG_CYCLES=20.
- Reset: hold `RST_N`=0 for 3 cycles with `BTN`=1 → all outputs 0. After release, PRESS arrives exactly 6 cycles later.
- Bounce: `BTN` pattern 1,1,0,1,1,0,1 (cycle by cycle), then 0 → no PRESS and `PRESSED` stays 0.
- Clean press held 30 cycles then released:
  - PRESS at cycle 6;
  - LONG at cycle 25, once only;
  - RELEASE 6 cycles after the falling edge;
  - `PRESSED` high from cycle 6 until the RELEASE cycle.
- Release glitch: while held, `BTN`=0 for 2 cycles then 1 → no RELEASE, `PRESSED` stays 1, no second LONG.
- ACTIVE_LOW=1: mirror the clean-press scenario with inverted `BTN` → identical output waveforms.
- Reset mid-hold: drive `RST_N`=0 while in HELD → `PRESSED`=0 the next cycle and no RELEASE pulse. With `BTN_LONG_PRESS_EN` undefined, `LONG` stays 0 throughout all scenarios.
